// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: sequencer states, default sizing and register constants.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    StRun,
    StMemWait
  } ctrl_state_e;

  localparam int unsigned MemTimeoutDefault = 64;
  localparam int unsigned CntWDefault       = 16;

  localparam logic [4:0] RegX0 = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: the load in EX writes a register the instruction in ID reads.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] if_id_rs1_i,
  input  logic [4:0] if_id_rs2_i,
  input  logic [4:0] id_ex_rd_i,
  input  logic       id_ex_mem_read_i,
  output logic       load_use_o
);

  // A load to x0 is architecturally discarded, so it never creates a dependency.
  assign load_use_o = id_ex_mem_read_i && (id_ex_rd_i != RegX0) &&
                      ((id_ex_rd_i == if_id_rs1_i) || (id_ex_rd_i == if_id_rs2_i));

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: load-use bubbles, taken-branch flushes and memory-wait freezes, plus
// saturating debug counters and a sticky memory-timeout flag.
module hazard_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault,
  parameter int unsigned CNT_W       = CntWDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_MemRead,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic             mem_err
);

  localparam int unsigned      WaitW     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(MEM_TIMEOUT - 1);
  localparam logic [WaitW-1:0] WaitMax   = WaitW'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

  ctrl_state_e      state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

  logic freeze;
  logic load_use;
  logic row_freeze;
  logic row_branch;
  logic row_stall;

  load_use_detect u_load_use_detect (
    .if_id_rs1_i      (if_id_rs1),
    .if_id_rs2_i      (if_id_rs2),
    .id_ex_rd_i       (id_ex_rd),
    .id_ex_mem_read_i (id_ex_MemRead),
    .load_use_o       (load_use)
  );

  assign freeze = dmem_req && !dmem_ready;

  // Priority: reset hold, freeze, taken branch (squashes any load-use), load-use, normal flow.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    row_freeze   = 1'b0;
    row_branch   = 1'b0;
    row_stall    = 1'b0;
    if (!reset || freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      row_freeze   = reset;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      row_branch  = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      row_stall    = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    unique case (state_q)
      StRun: begin
        wait_cnt_d = '0;
        if (freeze) begin
          state_d = StMemWait;
        end
      end
      StMemWait: begin
        if (dmem_ready) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else begin
          if (wait_cnt_q != WaitMax) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
          // The freeze keeps going after the flag sets; only memory can release it.
          if (wait_cnt_d >= WaitLimit) begin
            mem_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (row_stall && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (row_branch && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
    if (row_freeze && (freeze_cnt_q != CntMax)) begin
      freeze_cnt_d = freeze_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StRun;
      wait_cnt_q   <= '0;
      mem_err_q    <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_err_q    <= mem_err_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
  assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: a default-sized instance (a) and a small one (b, timeout 4,
// 2-bit counters) share stimulus; per-cycle expectations flow through a scoreboard queue.
module tb_hazard_stall_controller;

  localparam logic [6:0] CtrlNone = 7'b1100011;
  localparam logic [6:0] CtrlFrz  = 7'b0000000;
  localparam logic [6:0] CtrlBr   = 7'b1101111;
  localparam logic [6:0] CtrlLu   = 7'b0010011;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       rq;
    logic       ry;
    logic [6:0] ctrl;
    logic       err_b;
  } stim_t;

  typedef struct {
    logic [6:0] ctrl;
    logic       err_b;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
  logic       id_ex_MemRead, branch_taken, dmem_req, dmem_ready;

  logic        pcw_a, ifw_a, bub_a, iff_a, idf_a, exw_a, wbw_a, mem_err_a;
  logic        pcw_b, ifw_b, bub_b, iff_b, idf_b, exw_b, wbw_b, mem_err_b;
  logic [15:0] stall_cnt_a, flush_cnt_a, freeze_cnt_a;
  logic [1:0]  stall_cnt_b, flush_cnt_b, freeze_cnt_b;
  logic [6:0]  ctrl_a, ctrl_b;

  always #5 clk = ~clk;

  assign ctrl_a = {pcw_a, ifw_a, bub_a, iff_a, idf_a, exw_a, wbw_a};
  assign ctrl_b = {pcw_b, ifw_b, bub_b, iff_b, idf_b, exw_b, wbw_b};

  hazard_stall_controller #(.MEM_TIMEOUT(64), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_MemRead(id_ex_MemRead), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_write(pcw_a), .if_id_write(ifw_a),
    .id_ex_bubble(bub_a), .if_id_flush(iff_a), .id_ex_flush(idf_a), .ex_mem_write(exw_a),
    .mem_wb_write(wbw_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a),
    .freeze_cnt(freeze_cnt_a), .mem_err(mem_err_a)
  );

  hazard_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_MemRead(id_ex_MemRead), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_write(pcw_b), .if_id_write(ifw_b),
    .id_ex_bubble(bub_b), .if_id_flush(iff_b), .id_ex_flush(idf_b), .ex_mem_write(exw_b),
    .mem_wb_write(wbw_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b),
    .freeze_cnt(freeze_cnt_b), .mem_err(mem_err_b)
  );

  function automatic stim_t mk(input logic rn, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] d, input logic mr, input logic b,
                               input logic rq, input logic ry, input logic [6:0] c,
                               input logic eb);
    stim_t s;
    s.rst_n = rn; s.rs1 = r1; s.rs2 = r2; s.rd = d; s.mr = mr; s.br = b;
    s.rq = rq; s.ry = ry; s.ctrl = c; s.err_b = eb;
    return s;
  endfunction

  // Drives one cycle just after the edge, queues its expectation, and leaves time for settling.
  task automatic apply(input stim_t s, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    reset = s.rst_n; if_id_rs1 = s.rs1; if_id_rs2 = s.rs2; id_ex_rd = s.rd;
    id_ex_MemRead = s.mr; branch_taken = s.br; dmem_req = s.rq; dmem_ready = s.ry;
    e.ctrl = s.ctrl; e.err_b = s.err_b; e.tag = tag;
    sb.push_back(e);
    #3;
  endtask

  task automatic test_reset();
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(0, 5'd1, 5'd5, 5'd5, 1, 0, 0, 0, CtrlFrz, 0));
    st.push_back(mk(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, CtrlFrz, 0));
    foreach (st[i]) begin
      apply(st[i], $sformatf("reset[%0d]", i));
      e = sb.pop_front();
      n_chk++;
      if ({ctrl_a, ctrl_b, mem_err_a, mem_err_b} !== {e.ctrl, e.ctrl, 1'b0, e.err_b}) begin
        n_fail++;
        $display("FAIL %s: ctrl a=%b b=%b err a=%b b=%b, want ctrl=%b err_b=%b", e.tag,
                 ctrl_a, ctrl_b, mem_err_a, mem_err_b, e.ctrl, e.err_b);
      end
    end
    n_chk++;
    if (stall_cnt_a !== 16'd0 || flush_cnt_a !== 16'd0 || freeze_cnt_a !== 16'd0 ||
        stall_cnt_b !== 2'd0 || flush_cnt_b !== 2'd0 || freeze_cnt_b !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_counters: a=%0d/%0d/%0d b=%0d/%0d/%0d, want all 0", stall_cnt_a,
               flush_cnt_a, freeze_cnt_a, stall_cnt_b, flush_cnt_b, freeze_cnt_b);
    end
  endtask

  task automatic test_load_use();
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, CtrlFrz, 0));
    st.push_back(mk(1, 5'd1, 5'd5, 5'd5, 1, 0, 0, 0, CtrlLu, 0));
    st.push_back(mk(1, 5'd1, 5'd5, 5'd5, 0, 0, 0, 0, CtrlNone, 0));
    foreach (st[i]) begin
      apply(st[i], $sformatf("load_use[%0d]", i));
      e = sb.pop_front();
      n_chk++;
      if ({ctrl_a, ctrl_b, mem_err_a, mem_err_b} !== {e.ctrl, e.ctrl, 1'b0, e.err_b}) begin
        n_fail++;
        $display("FAIL %s: ctrl a=%b b=%b err a=%b b=%b, want ctrl=%b err_b=%b", e.tag,
                 ctrl_a, ctrl_b, mem_err_a, mem_err_b, e.ctrl, e.err_b);
      end
    end
    n_chk++;
    if (stall_cnt_a !== 16'd1 || stall_cnt_b !== 2'd1 || flush_cnt_a !== 16'd0 ||
        freeze_cnt_a !== 16'd0) begin
      n_fail++;
      $display("FAIL load_use_counters: stall a=%0d b=%0d flush=%0d freeze=%0d, want 1 1 0 0",
               stall_cnt_a, stall_cnt_b, flush_cnt_a, freeze_cnt_a);
    end
  endtask

  task automatic test_x0_load();
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, CtrlFrz, 0));
    st.push_back(mk(1, 5'd0, 5'd3, 5'd0, 1, 0, 0, 0, CtrlNone, 0));
    st.push_back(mk(1, 5'd7, 5'd2, 5'd7, 1, 0, 0, 0, CtrlLu, 0));
    st.push_back(mk(1, 5'd3, 5'd2, 5'd7, 1, 0, 0, 0, CtrlNone, 0));
    st.push_back(mk(1, 5'd7, 5'd7, 5'd7, 0, 0, 0, 0, CtrlNone, 0));
    foreach (st[i]) begin
      apply(st[i], $sformatf("x0_load[%0d]", i));
      e = sb.pop_front();
      n_chk++;
      if ({ctrl_a, ctrl_b, mem_err_a, mem_err_b} !== {e.ctrl, e.ctrl, 1'b0, e.err_b}) begin
        n_fail++;
        $display("FAIL %s: ctrl a=%b b=%b err a=%b b=%b, want ctrl=%b err_b=%b", e.tag,
                 ctrl_a, ctrl_b, mem_err_a, mem_err_b, e.ctrl, e.err_b);
      end
    end
    n_chk++;
    if (stall_cnt_a !== 16'd1) begin
      n_fail++;
      $display("FAIL x0_stall_cnt: got %0d, want 1", stall_cnt_a);
    end
  endtask

  task automatic test_branch_load_use();
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, CtrlFrz, 0));
    st.push_back(mk(1, 5'd5, 5'd9, 5'd5, 1, 1, 0, 0, CtrlBr, 0));
    st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, CtrlNone, 0));
    foreach (st[i]) begin
      apply(st[i], $sformatf("branch_lu[%0d]", i));
      e = sb.pop_front();
      n_chk++;
      if ({ctrl_a, ctrl_b, mem_err_a, mem_err_b} !== {e.ctrl, e.ctrl, 1'b0, e.err_b}) begin
        n_fail++;
        $display("FAIL %s: ctrl a=%b b=%b err a=%b b=%b, want ctrl=%b err_b=%b", e.tag,
                 ctrl_a, ctrl_b, mem_err_a, mem_err_b, e.ctrl, e.err_b);
      end
    end
    n_chk++;
    if (flush_cnt_a !== 16'd1 || stall_cnt_a !== 16'd0 || flush_cnt_b !== 2'd1) begin
      n_fail++;
      $display("FAIL branch_counters: flush a=%0d b=%0d stall=%0d, want 1 1 0", flush_cnt_a,
               flush_cnt_b, stall_cnt_a);
    end
  endtask

  task automatic test_freeze_branch();
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, CtrlFrz, 0));
    for (int k = 0; k < 3; k++) st.push_back(mk(1, 5'd1, 5'd5, 5'd5, 1, 1, 1, 0, CtrlFrz, 0));
    st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1, CtrlBr, 0));
    st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, CtrlNone, 0));
    foreach (st[i]) begin
      apply(st[i], $sformatf("freeze_branch[%0d]", i));
      e = sb.pop_front();
      n_chk++;
      if ({ctrl_a, ctrl_b, mem_err_a, mem_err_b} !== {e.ctrl, e.ctrl, 1'b0, e.err_b}) begin
        n_fail++;
        $display("FAIL %s: ctrl a=%b b=%b err a=%b b=%b, want ctrl=%b err_b=%b", e.tag,
                 ctrl_a, ctrl_b, mem_err_a, mem_err_b, e.ctrl, e.err_b);
      end
    end
    n_chk++;
    if (freeze_cnt_a !== 16'd3 || freeze_cnt_b !== 2'd3 || flush_cnt_a !== 16'd1 ||
        stall_cnt_a !== 16'd0) begin
      n_fail++;
      $display("FAIL freeze_counters: freeze a=%0d b=%0d flush=%0d stall=%0d, want 3 3 1 0",
               freeze_cnt_a, freeze_cnt_b, flush_cnt_a, stall_cnt_a);
    end
  endtask

  task automatic test_timeout();
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, CtrlFrz, 0));
    for (int k = 0; k < 6; k++) begin
      st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, CtrlFrz, (k >= 4) ? 1'b1 : 1'b0));
    end
    st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, CtrlNone, 1));
    st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, CtrlNone, 1));
    foreach (st[i]) begin
      apply(st[i], $sformatf("timeout[%0d]", i));
      e = sb.pop_front();
      n_chk++;
      if ({ctrl_a, ctrl_b, mem_err_a, mem_err_b} !== {e.ctrl, e.ctrl, 1'b0, e.err_b}) begin
        n_fail++;
        $display("FAIL %s: ctrl a=%b b=%b err a=%b b=%b, want ctrl=%b err_b=%b", e.tag,
                 ctrl_a, ctrl_b, mem_err_a, mem_err_b, e.ctrl, e.err_b);
      end
    end
    n_chk++;
    if (freeze_cnt_a !== 16'd6 || freeze_cnt_b !== 2'd3) begin
      n_fail++;
      $display("FAIL timeout_freeze_cnt: a=%0d b=%0d, want 6 3", freeze_cnt_a, freeze_cnt_b);
    end
    st.delete();
    st.push_back(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, CtrlFrz, 1));
    st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, CtrlNone, 0));
    foreach (st[i]) begin
      apply(st[i], $sformatf("timeout_clear[%0d]", i));
      e = sb.pop_front();
      n_chk++;
      if ({ctrl_a, ctrl_b, mem_err_a, mem_err_b} !== {e.ctrl, e.ctrl, 1'b0, e.err_b}) begin
        n_fail++;
        $display("FAIL %s: ctrl a=%b b=%b err a=%b b=%b, want ctrl=%b err_b=%b", e.tag,
                 ctrl_a, ctrl_b, mem_err_a, mem_err_b, e.ctrl, e.err_b);
      end
    end
    n_chk++;
    if (freeze_cnt_a !== 16'd0 || freeze_cnt_b !== 2'd0) begin
      n_fail++;
      $display("FAIL timeout_reset_cnt: a=%0d b=%0d, want 0 0", freeze_cnt_a, freeze_cnt_b);
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, CtrlFrz, 0));
    st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, CtrlFrz, 0));
    st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, CtrlFrz, 0));
    st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, CtrlNone, 0));
    for (int k = 0; k < 4; k++) st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, CtrlFrz, 0));
    st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, CtrlNone, 1));
    st.push_back(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, CtrlFrz, 1));
    foreach (st[i]) begin
      apply(st[i], $sformatf("back_to_back[%0d]", i));
      e = sb.pop_front();
      n_chk++;
      if ({ctrl_a, ctrl_b, mem_err_a, mem_err_b} !== {e.ctrl, e.ctrl, 1'b0, e.err_b}) begin
        n_fail++;
        $display("FAIL %s: ctrl a=%b b=%b err a=%b b=%b, want ctrl=%b err_b=%b", e.tag,
                 ctrl_a, ctrl_b, mem_err_a, mem_err_b, e.ctrl, e.err_b);
      end
    end
    n_chk++;
    if (freeze_cnt_a !== 16'd6 || freeze_cnt_b !== 2'd3) begin
      n_fail++;
      $display("FAIL b2b_freeze_cnt: a=%0d b=%0d, want 6 3", freeze_cnt_a, freeze_cnt_b);
    end
  endtask

  task automatic test_same_cycle_ready();
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, CtrlFrz, 0));
    st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, CtrlNone, 0));
    for (int k = 0; k < 4; k++) st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, CtrlFrz, 0));
    st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, CtrlNone, 1));
    st.push_back(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, CtrlFrz, 1));
    foreach (st[i]) begin
      apply(st[i], $sformatf("same_cycle_ready[%0d]", i));
      e = sb.pop_front();
      n_chk++;
      if ({ctrl_a, ctrl_b, mem_err_a, mem_err_b} !== {e.ctrl, e.ctrl, 1'b0, e.err_b}) begin
        n_fail++;
        $display("FAIL %s: ctrl a=%b b=%b err a=%b b=%b, want ctrl=%b err_b=%b", e.tag,
                 ctrl_a, ctrl_b, mem_err_a, mem_err_b, e.ctrl, e.err_b);
      end
    end
    n_chk++;
    if (freeze_cnt_a !== 16'd4) begin
      n_fail++;
      $display("FAIL same_cycle_freeze_cnt: got %0d, want 4", freeze_cnt_a);
    end
  endtask

  task automatic test_saturation();
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, CtrlFrz, 0));
    for (int k = 0; k < 5; k++) st.push_back(mk(1, 5'd4, 5'd6, 5'd6, 1, 0, 0, 0, CtrlLu, 0));
    st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, CtrlNone, 0));
    foreach (st[i]) begin
      apply(st[i], $sformatf("saturation[%0d]", i));
      e = sb.pop_front();
      n_chk++;
      if ({ctrl_a, ctrl_b, mem_err_a, mem_err_b} !== {e.ctrl, e.ctrl, 1'b0, e.err_b}) begin
        n_fail++;
        $display("FAIL %s: ctrl a=%b b=%b err a=%b b=%b, want ctrl=%b err_b=%b", e.tag,
                 ctrl_a, ctrl_b, mem_err_a, mem_err_b, e.ctrl, e.err_b);
      end
    end
    n_chk++;
    if (stall_cnt_a !== 16'd5 || stall_cnt_b !== 2'd3) begin
      n_fail++;
      $display("FAIL saturation_stall_cnt: a=%0d b=%0d, want 5 3", stall_cnt_a, stall_cnt_b);
    end
  endtask

  task automatic test_reset_mid_freeze();
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, CtrlFrz, 0));
    st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, CtrlFrz, 0));
    st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, CtrlFrz, 0));
    st.push_back(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, CtrlFrz, 0));
    for (int k = 0; k < 4; k++) st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, CtrlFrz, 0));
    st.push_back(mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, CtrlNone, 1));
    st.push_back(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, CtrlFrz, 1));
    foreach (st[i]) begin
      apply(st[i], $sformatf("reset_mid_freeze[%0d]", i));
      e = sb.pop_front();
      n_chk++;
      if ({ctrl_a, ctrl_b, mem_err_a, mem_err_b} !== {e.ctrl, e.ctrl, 1'b0, e.err_b}) begin
        n_fail++;
        $display("FAIL %s: ctrl a=%b b=%b err a=%b b=%b, want ctrl=%b err_b=%b", e.tag,
                 ctrl_a, ctrl_b, mem_err_a, mem_err_b, e.ctrl, e.err_b);
      end
    end
    n_chk++;
    if (freeze_cnt_a !== 16'd4) begin
      n_fail++;
      $display("FAIL reset_mid_freeze_cnt: got %0d, want 4", freeze_cnt_a);
    end
  endtask

  initial begin
    reset = 1'b0; if_id_rs1 = '0; if_id_rs2 = '0; id_ex_rd = '0;
    id_ex_MemRead = 1'b0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    test_reset();
    test_load_use();
    test_x0_load();
    test_branch_load_use();
    test_freeze_branch();
    test_timeout();
    test_back_to_back();
    test_same_cycle_ready();
    test_saturation();
    test_reset_mid_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
